// File: rtl/rom_socket_responder.sv
// rom_socket_responder
//
// Target-side responder for one FujiIIe ROM socket (diagnostics or monitor).
// It watches the socket select lines and 13-bit byte address, fetches the
// addressed byte from a backing memory over a req/ack handshake and returns
// it on the socket data lines.
//
// Parameters
//   MEM_ADDR_W  width of the backing memory byte address
//   BASE_ADDR   offset of this ROM image in backing memory
//               (mem_addr = BASE_ADDR + socket_a, modulo 2^MEM_ADDR_W)
//   TIMEOUT     cycles a fetch may wait for mem_ack (2..255)
//
// Ports
//   clk_core        core clock, all logic on the rising edge
//   reset_n         asynchronous active-low reset
//   socket_ce_n     ROM chip enable, active low
//   socket_oe_n     ROM output enable, active low
//   socket_a        ROM byte address
//   socket_d        ROM read data (8'hFF after reset or a timed-out fetch)
//   socket_d_valid  socket_d holds data for the currently selected address
//   mem_req         backing memory read request, held until mem_ack
//   mem_addr        backing memory byte address
//   mem_ack         one-cycle acknowledge, mem_rdata valid in the same cycle
//   mem_rdata       backing memory read data
//   timeout_err     sticky: some fetch timed out (cleared by reset only)
//
// Build option
//   ROM_SOCKET_CACHE_EN  when defined, adds a one-entry cache of the last
//                        successfully fetched byte; a selection that hits
//                        the cache is answered without a memory request.

module rom_socket_responder #(
    parameter int unsigned           MEM_ADDR_W = 20,
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned           TIMEOUT    = 64
) (
    input  logic                  clk_core,
    input  logic                  reset_n,
    input  logic                  socket_ce_n,
    input  logic                  socket_oe_n,
    input  logic [12:0]           socket_a,
    output logic [7:0]            socket_d,
    output logic                  socket_d_valid,
    output logic                  mem_req,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t                  state;
    logic [12:0]             cur_a;
    logic [7:0]              cnt;

    logic                    sel;
    logic                    addr_match;
    logic                    start_fetch;
    logic                    cache_hit;
    logic [7:0]              hit_data;
    logic [MEM_ADDR_W-1:0]   target_addr;

    assign sel         = ~socket_ce_n & ~socket_oe_n;
    assign addr_match  = (socket_a == cur_a);
    assign target_addr = BASE_ADDR + MEM_ADDR_W'(socket_a);

    // A new lookup starts on a fresh selection from IDLE or on an address
    // change while a byte is being held. An address change during FETCH is
    // not handled here: the running fetch completes first and the lookup is
    // restarted through IDLE one cycle later.
    assign start_fetch = sel && ((state == IDLE) ||
                                 ((state == HOLD) && !addr_match));

`ifdef ROM_SOCKET_CACHE_EN
    logic        cache_valid;
    logic [12:0] cache_tag;
    logic [7:0]  cache_data;

    // Filled on every acknowledged fetch; timed-out fetches never reach here.
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
        end else if ((state == FETCH) && mem_ack) begin
            cache_valid <= 1'b1;
            cache_tag   <= cur_a;
            cache_data  <= mem_rdata;
        end
    end

    assign cache_hit = cache_valid && (cache_tag == socket_a);
    assign hit_data  = cache_data;
`else
    assign cache_hit = 1'b0;
    assign hit_data  = 8'hFF;
`endif

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cur_a          <= '0;
            cnt            <= '0;
            socket_d       <= 8'hFF;
            socket_d_valid <= 1'b0;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
            timeout_err    <= 1'b0;
        end else if (start_fetch) begin
            cur_a <= socket_a;
            cnt   <= '0;
            if (cache_hit) begin
                socket_d       <= hit_data;
                socket_d_valid <= 1'b1;
                state          <= HOLD;
            end else begin
                mem_addr       <= target_addr;
                mem_req        <= 1'b1;
                socket_d_valid <= 1'b0;
                state          <= FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        socket_d <= mem_rdata;
                        // Only present the byte if the host is still looking
                        // at the address it was fetched for.
                        if (sel && addr_match) begin
                            socket_d_valid <= 1'b1;
                            state          <= HOLD;
                        end else begin
                            socket_d_valid <= 1'b0;
                            state          <= IDLE;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        mem_req     <= 1'b0;
                        socket_d    <= 8'hFF;
                        timeout_err <= 1'b1;
                        if (sel && addr_match) begin
                            socket_d_valid <= 1'b1;
                            state          <= HOLD;
                        end else begin
                            socket_d_valid <= 1'b0;
                            state          <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    // Selected with a changed address is taken by start_fetch.
                    if (!sel) begin
                        socket_d_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    // IDLE without a selection: nothing to do; mem_ack
                    // arriving here is ignored.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_socket_responder.sv
module tb_rom_socket_responder;

    localparam logic [19:0] BASE = 20'hFFFFF;
    localparam int          TMO  = 8;

    localparam int W_REQ     = 0;
    localparam int W_VALID   = 1;
    localparam int W_NOREQ   = 2;
    localparam int W_NOVALID = 3;

    logic        clk;
    logic        reset_n;
    logic        ce_n;
    logic        oe_n;
    logic [12:0] a;
    logic [7:0]  socket_d;
    logic        socket_d_valid;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        timeout_err;

    // Responder controls, written by the stimulus process only.
    logic        ack_on;
    int          ack_delay;
    logic        spurious;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    rom_socket_responder #(
        .MEM_ADDR_W (20),
        .BASE_ADDR  (BASE),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_core       (clk),
        .reset_n        (reset_n),
        .socket_ce_n    (ce_n),
        .socket_oe_n    (oe_n),
        .socket_a       (a),
        .socket_d       (socket_d),
        .socket_d_valid (socket_d_valid),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory image.
    function automatic logic [7:0] img(input logic [19:0] ad);
        if (ad == 20'h01233) return 8'hA5;
        return ad[7:0] ^ 8'h3C;
    endfunction

    // What a valid socket byte must be for socket address sa.
    function automatic logic [7:0] exp_byte(input logic [12:0] sa);
        logic [19:0] ad;
        ad = BASE + {7'b0, sa};
        return ack_on ? img(ad) : 8'hFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Counts rising edges until the condition is seen at the following
    // falling edge; returns -1 if max edges pass without it.
    task automatic wait_sig(input int which, input int max, output int n);
        logic hit;
        n = 0;
        forever begin
            @(posedge clk);
            n++;
            @(negedge clk);
            case (which)
                W_REQ:     hit = mem_req;
                W_VALID:   hit = socket_d_valid;
                W_NOREQ:   hit = !mem_req;
                default:   hit = !socket_d_valid;
            endcase
            if (hit) break;
            if (n >= max) begin
                n = -1;
                break;
            end
        end
    endtask

    // Backing memory: acks ack_delay cycles after mem_req rises.
    initial begin : responder
        logic req_prev;
        int   cnt;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        req_prev  = 1'b0;
        cnt       = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (spurious) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'h77;
                spurious  = 1'b0;
            end else if (mem_req && reset_n) begin
                if (!req_prev) cnt = 0;
                else cnt++;
                if (ack_on && req_prev && cnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = img(mem_addr);
                end
            end
            req_prev = mem_req && reset_n;
        end
    end

    // Cycle-by-cycle checks against the socket/memory contract.
    initial begin : compare
        logic        s_sel;
        logic        s_ack;
        logic        prev_req;
        logic        exp_to;
        logic [12:0] s_a;
        logic [19:0] req_addr;
        int          run_len;
        prev_req = 1'b0;
        exp_to   = 1'b0;
        run_len  = 0;
        req_addr = '0;
        forever begin
            @(posedge clk);
            s_sel = !ce_n && !oe_n;
            s_a   = a;
            s_ack = mem_ack;
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_d", socket_d, 8'hFF);
                chk("rst_valid", socket_d_valid, 1'b0);
                chk("rst_req", mem_req, 1'b0);
                chk("rst_err", timeout_err, 1'b0);
                prev_req = 1'b0;
                exp_to   = 1'b0;
                run_len  = 0;
            end else begin
                if (socket_d_valid) begin
                    chk("valid_sel", s_sel, 1'b1);
                    chk("valid_data", socket_d, exp_byte(s_a));
                end
                if (mem_req) begin
                    if (!prev_req) begin
                        req_addr = BASE + {7'b0, s_a};
                        chk("req_sel", s_sel, 1'b1);
                        chk("req_addr", mem_addr, req_addr);
                        run_len = 1;
                    end else begin
                        chk("req_addr_hold", mem_addr, req_addr);
                        run_len++;
                    end
                    if (run_len > TMO) chk("req_len", run_len, TMO);
                end else if (prev_req) begin
                    if (!s_ack) begin
                        chk("timeout_len", run_len, TMO);
                        exp_to = 1'b1;
                    end
                    run_len = 0;
                end
                chk("timeout_err", timeout_err, exp_to);
                prev_req = mem_req;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        reset_n   = 1'b0;
        ce_n      = 1'b1;
        oe_n      = 1'b1;
        a         = '0;
        ack_on    = 1'b1;
        ack_delay = 3;
        spurious  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_d", socket_d, 8'hFF);
        chk("init_addr", mem_addr, 20'h00000);
        reset_n = 1'b1;

        // Basic read, ack 3 cycles after request.
        @(negedge clk);
        a = 13'h1234; ce_n = 1'b0; oe_n = 1'b0;
        wait_sig(W_REQ, 10, n);
        chk("basic_req_lat", n, 1);
        chk("basic_addr", mem_addr, 20'h01233);
        wait_sig(W_VALID, 20, n);
        chk("basic_valid_lat", n, 4);
        chk("basic_data", socket_d, 8'hA5);
        chk("basic_req_drop", mem_req, 1'b0);
        ce_n = 1'b1;
        wait_sig(W_NOVALID, 5, n);
        chk("basic_deselect", n, 1);

        // Ack with nothing outstanding changes nothing.
        spurious = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("spur_req", mem_req, 1'b0);
        chk("spur_valid", socket_d_valid, 1'b0);
        chk("spur_d", socket_d, 8'hA5);

        // Address change mid-fetch.
        a = 13'h0010; ce_n = 1'b0;
        wait_sig(W_REQ, 10, n);
        chk("chg_req1_lat", n, 1);
        chk("chg_addr1", mem_addr, 20'h0000F);
        a = 13'h0011;
        wait_sig(W_NOREQ, 20, n);
        chk("chg_req1_len", n, 4);
        wait_sig(W_REQ, 10, n);
        chk("chg_req2_lat", n, 1);
        chk("chg_addr2", mem_addr, 20'h00010);
        wait_sig(W_VALID, 20, n);
        chk("chg_valid_lat", n, 4);
        chk("chg_data", socket_d, 8'h2C);

        // Address change while holding: refetch at once.
        a = 13'h1234;
        wait_sig(W_REQ, 10, n);
        chk("hold_chg_req_lat", n, 1);
        chk("hold_chg_valid", socket_d_valid, 1'b0);
        wait_sig(W_VALID, 20, n);
        chk("hold_chg_valid_lat", n, 4);
        chk("hold_chg_data", socket_d, 8'hA5);
        ce_n = 1'b1;
        wait_sig(W_NOVALID, 5, n);

        // Address wrap and minimum ack latency.
        a = 13'h0001; ack_delay = 1; ce_n = 1'b0;
        wait_sig(W_REQ, 10, n);
        chk("wrap_addr", mem_addr, 20'h00000);
        wait_sig(W_VALID, 20, n);
        chk("wrap_valid_lat", n, 2);
        chk("wrap_data", socket_d, 8'h3C);
        ce_n = 1'b1;
        wait_sig(W_NOVALID, 5, n);

        // Reselect of the same address, then a neighbouring one.
        a = 13'h0100; ack_delay = 2; ce_n = 1'b0;
        wait_sig(W_REQ, 10, n);
        chk("c_first_req", n, 1);
        wait_sig(W_VALID, 20, n);
        chk("c_first_lat", n, 3);
        chk("c_first_data", socket_d, 8'hC3);
        ce_n = 1'b1;
        wait_sig(W_NOVALID, 5, n);
        ce_n = 1'b0;
`ifdef ROM_SOCKET_CACHE_EN
        wait_sig(W_VALID, 10, n);
        chk("c_hit_lat", n, 1);
        chk("c_hit_noreq", mem_req, 1'b0);
        chk("c_hit_data", socket_d, 8'hC3);
`else
        wait_sig(W_REQ, 10, n);
        chk("c_refetch_req", n, 1);
        wait_sig(W_VALID, 20, n);
        chk("c_refetch_lat", n, 3);
`endif
        a = 13'h0101;
        wait_sig(W_REQ, 10, n);
        chk("c_miss_req", n, 1);
        chk("c_miss_addr", mem_addr, 20'h00100);
        wait_sig(W_VALID, 20, n);
        chk("c_miss_lat", n, 3);
        chk("c_miss_data", socket_d, 8'h3C);
        ce_n = 1'b1;
        wait_sig(W_NOVALID, 5, n);

        // Timeout: never acknowledged.
        ack_on = 1'b0;
        @(negedge clk);
        a = 13'h0ABC; ce_n = 1'b0;
        wait_sig(W_REQ, 10, n);
        chk("to_req_lat", n, 1);
        wait_sig(W_NOREQ, 20, n);
        chk("to_req_len", n, 8);
        chk("to_d", socket_d, 8'hFF);
        chk("to_valid", socket_d_valid, 1'b1);
        chk("to_err", timeout_err, 1'b1);
        ce_n = 1'b1;
        wait_sig(W_NOVALID, 5, n);
        chk("to_deselect", n, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("to_err_sticky", timeout_err, 1'b1);

        // Asynchronous reset in the middle of a fetch.
        a = 13'h0055; ce_n = 1'b0;
        wait_sig(W_REQ, 10, n);
        chk("rm_req", n, 1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rm_req_low", mem_req, 1'b0);
        chk("rm_valid", socket_d_valid, 1'b0);
        chk("rm_d", socket_d, 8'hFF);
        chk("rm_err", timeout_err, 1'b0);
        chk("rm_addr", mem_addr, 20'h00000);
        ce_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ack_on  = 1'b1;
        ack_delay = 3;

        // Recovery after reset.
        @(negedge clk);
        a = 13'h1234; ce_n = 1'b0;
        wait_sig(W_REQ, 10, n);
        chk("post_req_lat", n, 1);
        wait_sig(W_VALID, 20, n);
        chk("post_valid_lat", n, 4);
        chk("post_data", socket_d, 8'hA5);
        ce_n = 1'b1;
        wait_sig(W_NOVALID, 5, n);
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
